// File: rtl/arbitro_entrada_rr.sv
// Weighted round-robin arbiter draining four FWFT input FIFOs into one output FIFO.
// Each queue may hold the grant for up to BURST consecutive pops before the pointer rotates.
module arbitro_entrada_rr #(
  parameter int DATA_W = 6,
  parameter int BURST  = 2
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic [3:0]        state,
  input  logic              empty0,
  input  logic              empty1,
  input  logic              empty2,
  input  logic              empty3,
  input  logic [DATA_W-1:0] data_in0,
  input  logic [DATA_W-1:0] data_in1,
  input  logic [DATA_W-1:0] data_in2,
  input  logic [DATA_W-1:0] data_in3,
  input  logic              almost_full_out,
  output logic              pop0,
  output logic              pop1,
  output logic              pop2,
  output logic              pop3,
  output logic              push_out,
  output logic [DATA_W-1:0] data_out,
  output logic              idle
);

  localparam logic [3:0] ST_RESET  = 4'b0001;
  localparam logic [3:0] ST_IDLE   = 4'b0100;
  localparam logic [3:0] ST_ACTIVE = 4'b1000;
  localparam logic [3:0] BURST_C   = 4'(BURST);

  logic [3:0]        empty_s;
  logic [DATA_W-1:0] data_s [4];
  logic [7:0]        avail_dbl_s;
  logic [3:0]        avail_s;
  logic              enable_s;
  logic              grant_s;
  logic [1:0]        offset_s;
  logic [1:0]        grant_idx_s;
  logic [1:0]        ptr_r;
  logic [3:0]        burst_cnt_r;

  assign empty_s   = {empty3, empty2, empty1, empty0};
  assign data_s[0] = data_in0;
  assign data_s[1] = data_in1;
  assign data_s[2] = data_in2;
  assign data_s[3] = data_in3;
  assign enable_s  = reset_L & ((state == ST_IDLE) | (state == ST_ACTIVE));

  // avail_s[j] says whether queue (ptr+j) mod 4 holds a word
  assign avail_dbl_s = {~empty_s, ~empty_s};
  assign avail_s     = 4'(avail_dbl_s >> ptr_r);

  // Grant selection: stay on ptr while the burst allows, otherwise search forward
  always_comb begin
    grant_s  = 1'b0;
    offset_s = 2'd0;
    if (enable_s && !almost_full_out) begin
      if (avail_s[0] && (burst_cnt_r < BURST_C)) begin
        grant_s  = 1'b1;
        offset_s = 2'd0;
      end else if (avail_s[1]) begin
        grant_s  = 1'b1;
        offset_s = 2'd1;
      end else if (avail_s[2]) begin
        grant_s  = 1'b1;
        offset_s = 2'd2;
      end else if (avail_s[3]) begin
        grant_s  = 1'b1;
        offset_s = 2'd3;
      end else begin
        grant_s  = 1'b0;
        offset_s = 2'd0;
      end
    end else begin
      grant_s  = 1'b0;
      offset_s = 2'd0;
    end
  end

  assign grant_idx_s = ptr_r + offset_s;

  assign pop0 = grant_s & (grant_idx_s == 2'd0);
  assign pop1 = grant_s & (grant_idx_s == 2'd1);
  assign pop2 = grant_s & (grant_idx_s == 2'd2);
  assign pop3 = grant_s & (grant_idx_s == 2'd3);

  // Pointer/burst bookkeeping and the registered push datapath
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      ptr_r       <= 2'd0;
      burst_cnt_r <= 4'd0;
      push_out    <= 1'b0;
      data_out    <= '0;
    end else if (state == ST_RESET) begin
      ptr_r       <= 2'd0;
      burst_cnt_r <= 4'd0;
      push_out    <= 1'b0;
    end else if (grant_s) begin
      push_out <= 1'b1;
      data_out <= data_s[grant_idx_s];
      if (grant_idx_s == ptr_r) begin
        if ((burst_cnt_r + 4'd1) >= BURST_C) begin
          ptr_r       <= ptr_r + 2'd1;
          burst_cnt_r <= 4'd0;
        end else begin
          burst_cnt_r <= burst_cnt_r + 4'd1;
        end
      end else if (BURST_C == 4'd1) begin
        // a one-word burst is already exhausted by the jump itself
        ptr_r       <= grant_idx_s + 2'd1;
        burst_cnt_r <= 4'd0;
      end else begin
        ptr_r       <= grant_idx_s;
        burst_cnt_r <= 4'd1;
      end
    end else begin
      push_out <= 1'b0;
    end
  end

  assign idle = empty0 & empty1 & empty2 & empty3 & ~push_out;

endmodule

// File: tb/tb_arbitro_entrada_rr.sv
// Directed bench for arbitro_entrada_rr: FWFT queue models feed the DUT, a scoreboard
// queue holds hand-computed output words and a negedge monitor checks every push.
module tb_arbitro_entrada_rr;

  localparam logic [3:0] ST_RESET  = 4'b0001;
  localparam logic [3:0] ST_INIT   = 4'b0010;
  localparam logic [3:0] ST_ACTIVE = 4'b1000;

  logic       clk = 1'b0;
  logic       reset_L;
  logic [3:0] state;
  logic       empty0, empty1, empty2, empty3;
  logic [5:0] data_in0, data_in1, data_in2, data_in3;
  logic       almost_full_out;
  logic       pop0, pop1, pop2, pop3;
  logic       push_out;
  logic [5:0] data_out;
  logic       idle;

  logic [5:0] q0[$], q1[$], q2[$], q3[$];
  logic [5:0] exp_q[$];
  logic [5:0] exp_w;
  int         n_cmp = 0;
  int         n_bad = 0;
  string      tag = "T1";

  int         p2[10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
  logic [5:0] e2[10] = '{6'd1, 6'd2, 6'd9, 6'd10, 6'd17, 6'd18, 6'd25, 6'd26, 6'd3, 6'd4};
  int         p4[13] = '{0, 0, -1, -1, -1, 1, 1, 2, 2, 3, 3, 0, 0};
  int         p5[8]  = '{0, 0, 1, -1, 0, 0, 1, 1};
  logic [5:0] e5[7]  = '{6'd1, 6'd2, 6'd9, 6'd3, 6'd4, 6'd10, 6'd11};
  int         p6[4]  = '{0, 0, 1, 1};
  logic [5:0] e6[6]  = '{6'd1, 6'd2, 6'd3, 6'd4, 6'd10, 6'd11};

  always #5 clk = ~clk;

  arbitro_entrada_rr #(.DATA_W(6), .BURST(2)) dut (
    .clk(clk), .reset_L(reset_L), .state(state),
    .empty0(empty0), .empty1(empty1), .empty2(empty2), .empty3(empty3),
    .data_in0(data_in0), .data_in1(data_in1), .data_in2(data_in2), .data_in3(data_in3),
    .almost_full_out(almost_full_out),
    .pop0(pop0), .pop1(pop1), .pop2(pop2), .pop3(pop3),
    .push_out(push_out), .data_out(data_out), .idle(idle)
  );

  task automatic refresh();
    empty0   = (q0.size() == 0);
    empty1   = (q1.size() == 0);
    empty2   = (q2.size() == 0);
    empty3   = (q3.size() == 0);
    data_in0 = empty0 ? 6'd0 : q0[0];
    data_in1 = empty1 ? 6'd0 : q1[0];
    data_in2 = empty2 ? 6'd0 : q2[0];
    data_in3 = empty3 ? 6'd0 : q3[0];
  endtask

  task automatic load_all();
    q0 = '{6'd1, 6'd2, 6'd3, 6'd4};
    q1 = '{6'd9, 6'd10, 6'd11, 6'd12};
    q2 = '{6'd17, 6'd18, 6'd19, 6'd20};
    q3 = '{6'd25, 6'd26, 6'd27, 6'd28};
    refresh();
  endtask

  task automatic flush();
    q0.delete(); q1.delete(); q2.delete(); q3.delete();
    refresh();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s/%s: got %0h, required %0h", tag, name, act, req);
    end
  endtask

  // One clock cycle: check the pop vector just before the edge, then consume popped words.
  task automatic step(input int ep);
    logic [3:0] pv;
    logic [3:0] ev;
    @(negedge clk);
    #4;
    pv = {pop3, pop2, pop1, pop0};
    ev = (ep < 0) ? 4'b0000 : 4'(1 << ep);
    chk("pop", 32'(pv), 32'(ev));
    @(posedge clk);
    #1;
    if (pv[0]) void'(q0.pop_front());
    if (pv[1]) void'(q1.pop_front());
    if (pv[2]) void'(q2.pop_front());
    if (pv[3]) void'(q3.pop_front());
    refresh();
  endtask

  task automatic clr();
    state           = ST_RESET;
    almost_full_out = 1'b0;
    step(-1);
    flush();
    state = ST_INIT;
  endtask

  // Scoreboard monitor: every push must match the oldest outstanding expected word
  always @(negedge clk) begin
    if (reset_L === 1'b1 && push_out === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL %s/push: got unexpected push data_out=%0d, required no push", tag, data_out);
      end else begin
        exp_w = exp_q.pop_front();
        if (data_out !== exp_w) begin
          n_bad++;
          $display("FAIL %s/data_out: got %0d, required %0d", tag, data_out, exp_w);
        end
      end
    end
  end

  initial begin
    reset_L         = 1'b0;
    state           = ST_ACTIVE;
    almost_full_out = 1'b0;
    load_all();
    #2;
    chk("pop_rst", 32'({pop3, pop2, pop1, pop0}), 32'd0);
    chk("push_rst", 32'(push_out), 32'd0);
    chk("data_rst", 32'(data_out), 32'd0);
    chk("idle_rst", 32'(idle), 32'd0);
    step(-1);
    state   = ST_INIT;
    reset_L = 1'b1;

    tag   = "T2";
    state = ST_ACTIVE;
    foreach (e2[i]) exp_q.push_back(e2[i]);
    for (int i = 0; i < 10; i++) step(p2[i]);
    clr();

    tag = "T3";
    q2  = '{6'd5, 6'd6, 6'd7};
    refresh();
    exp_q.push_back(6'd5); exp_q.push_back(6'd6); exp_q.push_back(6'd7);
    state = ST_ACTIVE;
    step(2); step(2); step(2); step(-1);
    chk("idle_end", 32'(idle), 32'd1);
    clr();

    tag = "T4";
    load_all();
    foreach (e2[i]) exp_q.push_back(e2[i]);
    state = ST_ACTIVE;
    for (int i = 0; i < 13; i++) begin
      almost_full_out = (i >= 2 && i <= 4);
      step(p4[i]);
    end
    clr();

    tag = "T5";
    load_all();
    foreach (e5[i]) exp_q.push_back(e5[i]);
    for (int i = 0; i < 8; i++) begin
      state = (i == 3) ? ST_RESET : ST_ACTIVE;
      step(p5[i]);
    end
    clr();

    tag = "T6";
    load_all();
    foreach (e6[i]) exp_q.push_back(e6[i]);
    state = ST_ACTIVE;
    step(0); step(0); step(1);
    #1 reset_L = 1'b0;
    #1;
    chk("push_async", 32'(push_out), 32'd0);
    chk("data_async", 32'(data_out), 32'd0);
    chk("pop_async", 32'({pop3, pop2, pop1, pop0}), 32'd0);
    step(-1);
    reset_L = 1'b1;
    for (int i = 0; i < 4; i++) step(p6[i]);
    clr();

    tag = "END";
    step(-1);
    step(-1);
    chk("leftover_expected", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
